// File: rtl/ave_filterbank_int_if.sv
// Stream bundle for the averaging filterbank: sample beats and config in,
// integrated beats and status out.
interface ave_filterbank_int_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int NOF_CHANNEL = 128,
  parameter int OUT_WIDTH   = 16
);
  localparam int LANES = NOF_CHANNEL / 2;

  logic [DATA_WIDTH*LANES-1:0] data_in;
  logic                        data_in_valid;
  logic                        sync;
  logic [3:0]                  log2_nave;
  logic                        mode;
  logic [OUT_WIDTH*LANES-1:0]  data_out;
  logic                        data_out_valid;
  logic                        sat_flag;
  logic [31:0]                 int_count;

  modport master (
    output data_in, data_in_valid, sync, log2_nave, mode,
    input  data_out, data_out_valid, sat_flag, int_count
  );

  modport slave (
    input  data_in, data_in_valid, sync, log2_nave, mode,
    output data_out, data_out_valid, sat_flag, int_count
  );
endinterface

// File: rtl/ave_filterbank_int.sv
// Per-lane 2^k integrating filterbank: rounded mean or saturated sum per
// completed integration, with a shared beat counter and config latch.
module ave_filterbank_int #(
  parameter int DATA_WIDTH    = 16,
  parameter int NOF_CHANNEL   = 128,
  parameter int MAX_LOG2_NAVE = 8,
  parameter int OUT_WIDTH     = 16
) (
  input logic              clk_data,
  input logic              rst,
  ave_filterbank_int_if.slave bus
);
  localparam int LANES = NOF_CHANNEL / 2;
  localparam int ACC_W = DATA_WIDTH + MAX_LOG2_NAVE;
  localparam int SW    = (ACC_W > OUT_WIDTH) ? ACC_W : OUT_WIDTH;
  localparam logic [3:0]    K_MAX   = 4'(MAX_LOG2_NAVE);
  localparam logic [SW-1:0] OUT_MAX = SW'({OUT_WIDTH{1'b1}});

  logic [MAX_LOG2_NAVE-1:0] cnt, cnt_eff, cnt_last;
  logic [3:0]               k_lat, k_req, k_eff;
  logic                     mode_lat, mode_eff;
  logic                     first_beat, final_beat, any_sat;
  logic [ACC_W-1:0]         rnd;
  logic [ACC_W-1:0]         acc    [LANES];
  logic [ACC_W-1:0]         sum_w  [LANES];
  logic [ACC_W-1:0]         mean_w [LANES];
  logic [SW-1:0]            sum_x  [LANES];
  logic [OUT_WIDTH*LANES-1:0] out_next;

  always_comb begin
    k_req      = (bus.log2_nave > K_MAX) ? K_MAX : bus.log2_nave;
    first_beat = bus.data_in_valid && (bus.sync || cnt == '0);
    k_eff      = first_beat ? k_req : k_lat;
    mode_eff   = first_beat ? bus.mode : mode_lat;
    // A sync beat restarts the count, so it is compared as beat 0.
    cnt_eff    = first_beat ? '0 : cnt;
    cnt_last   = '0;
    for (int unsigned i = 0; i < MAX_LOG2_NAVE; i++)
      cnt_last[i] = (i < 32'(k_eff));
    final_beat = bus.data_in_valid && (cnt_eff == cnt_last);
    rnd        = (k_eff == '0) ? '0 : (ACC_W'(1) << (k_eff - 4'd1));

    any_sat  = 1'b0;
    out_next = '0;
    for (int unsigned m = 0; m < LANES; m++) begin
      sum_w[m]  = (first_beat ? '0 : acc[m])
                + ACC_W'(bus.data_in[m*DATA_WIDTH +: DATA_WIDTH]);
      mean_w[m] = (sum_w[m] + rnd) >> k_eff;
      sum_x[m]  = SW'(sum_w[m]);
      if (mode_eff) begin
        if (sum_x[m] > OUT_MAX) begin
          out_next[m*OUT_WIDTH +: OUT_WIDTH] = '1;
          any_sat = 1'b1;
        end else begin
          out_next[m*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(sum_x[m]);
        end
      end else begin
        out_next[m*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(mean_w[m][DATA_WIDTH-1:0]);
      end
    end
  end

  always_ff @(posedge clk_data) begin
    if (rst) begin
      cnt                <= '0;
      k_lat              <= '0;
      mode_lat           <= 1'b0;
      bus.data_out       <= '0;
      bus.data_out_valid <= 1'b0;
      bus.sat_flag       <= 1'b0;
      bus.int_count      <= '0;
      for (int unsigned m = 0; m < LANES; m++)
        acc[m] <= '0;
    end else begin
      bus.data_out_valid <= 1'b0;
      if (bus.data_in_valid) begin
        if (first_beat) begin
          k_lat    <= k_req;
          mode_lat <= bus.mode;
        end
        for (int unsigned m = 0; m < LANES; m++)
          acc[m] <= sum_w[m];
        cnt <= final_beat ? '0 : cnt_eff + MAX_LOG2_NAVE'(1);
        if (final_beat) begin
          bus.data_out       <= out_next;
          bus.data_out_valid <= 1'b1;
          bus.int_count      <= bus.int_count + 32'd1;
          if (mode_eff && any_sat)
            bus.sat_flag <= 1'b1;
        end
      end else if (bus.sync) begin
        cnt <= '0;
      end
    end
  end
endmodule

// File: tb/tb_ave_filterbank_int.sv
// Directed bench for ave_filterbank_int with a reference model feeding an
// expected-output queue that a monitor drains on each data_out_valid.
module tb_ave_filterbank_int;
  localparam int DW    = 16;
  localparam int NOFC  = 8;
  localparam int LANES = NOFC / 2;
  localparam int MAXK  = 8;
  localparam int OW    = 16;

  typedef struct {
    logic [63:0] data;
    logic [31:0] count;
    logic        sat;
  } exp_t;

  logic clk_data = 1'b0;
  logic rst;
  always #5 clk_data = ~clk_data;

  ave_filterbank_int_if #(.DATA_WIDTH(DW), .NOF_CHANNEL(NOFC), .OUT_WIDTH(OW)) bus ();

  ave_filterbank_int #(
    .DATA_WIDTH(DW), .NOF_CHANNEL(NOFC), .MAX_LOG2_NAVE(MAXK), .OUT_WIDTH(OW)
  ) dut (
    .clk_data(clk_data),
    .rst     (rst),
    .bus     (bus)
  );

  int   tests = 0;
  int   fails = 0;
  exp_t q[$];
  exp_t mon_e;

  longint      macc [LANES];
  int          mcnt, mk;
  bit          mmode, msat;
  int unsigned mcount;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < LANES; m++) macc[m] = 0;
    mcnt = 0; mk = 0; mmode = 0; msat = 0; mcount = 0;
    q.delete();
  endtask

  task automatic beat(input logic [63:0] v, input bit s);
    bit          first, fin;
    longint      sv;
    logic [63:0] ov;
    exp_t        e;
    bus.data_in       = v;
    bus.data_in_valid = 1'b1;
    bus.sync          = s;
    first = s || (mcnt == 0);
    if (first) begin
      mk    = (int'(bus.log2_nave) > MAXK) ? MAXK : int'(bus.log2_nave);
      mmode = bus.mode;
      mcnt  = 0;
    end
    fin = (mcnt == (1 << mk) - 1);
    ov  = '0;
    for (int m = 0; m < LANES; m++) begin
      sv      = (first ? 64'sd0 : macc[m]) + longint'(v[m*DW +: DW]);
      macc[m] = sv;
      if (mmode) begin
        if (sv > 65535) begin
          ov[m*OW +: OW] = 16'hFFFF;
          if (fin) msat = 1;
        end else begin
          ov[m*OW +: OW] = sv[15:0];
        end
      end else begin
        ov[m*OW +: OW] = 16'((sv + ((mk != 0) ? (64'sd1 << (mk - 1)) : 64'sd0)) >>> mk);
      end
    end
    if (fin) begin
      mcount++;
      e.data = ov; e.count = mcount; e.sat = msat;
      q.push_back(e);
      mcnt = 0;
    end else begin
      mcnt++;
    end
    @(posedge clk_data); #1;
    bus.data_in_valid = 1'b0;
    bus.sync          = 1'b0;
    chk("beat_valid", bus.data_out_valid, fin);
  endtask

  task automatic idle(input int n, input bit s);
    for (int i = 0; i < n; i++) begin
      bus.data_in_valid = 1'b0;
      bus.sync          = s;
      if (s) mcnt = 0;
      @(posedge clk_data); #1;
      bus.sync = 1'b0;
      chk("idle_valid", bus.data_out_valid, 0);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_data"},  bus.data_out, 0);
    chk({tag, "_valid"}, bus.data_out_valid, 0);
    chk({tag, "_sat"},   bus.sat_flag, 0);
    chk({tag, "_count"}, bus.int_count, 0);
  endtask

  always @(negedge clk_data) begin
    if (!rst && bus.data_out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out", bus.data_out_valid, 0);
      end else begin
        mon_e = q.pop_front();
        chk("out_data",  bus.data_out,  mon_e.data);
        chk("out_count", bus.int_count, mon_e.count);
        chk("out_sat",   bus.sat_flag,  mon_e.sat);
      end
    end
  end

  initial begin
    logic [63:0] v;
    rst = 1'b1;
    bus.data_in = '0; bus.data_in_valid = 1'b0; bus.sync = 1'b0;
    bus.log2_nave = 4'd0; bus.mode = 1'b0;
    model_reset();
    repeat (3) @(posedge clk_data);
    #1;
    chk_zero_outputs("reset");
    rst = 1'b0;

    // k=2 mean, lane 0 = 10..13 -> 12
    bus.log2_nave = 4'd2; bus.mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      v = {16'(40 + i), 16'(30 + 3 * i), 16'(1000 * i + 7), 16'(10 + i)};
      beat(v, 1'b0);
    end
    chk("t1_lane0", bus.data_out[15:0], 16'd12);
    chk("t1_count", bus.int_count, 32'd1);

    // k=3 saturated sum, then small sum with sticky flag
    bus.log2_nave = 4'd3; bus.mode = 1'b1;
    for (int i = 0; i < 8; i++) beat({4{16'hFFFF}}, 1'b0);
    chk("t2_sat_data", bus.data_out, {4{16'hFFFF}});
    chk("t2_sat_flag", bus.sat_flag, 1);
    for (int i = 0; i < 8; i++) beat({4{16'd1}}, 1'b0);
    chk("t2_small_data", bus.data_out, {4{16'd8}});
    chk("t2_sticky",     bus.sat_flag, 1);

    // k=0 pass-through on continuous ramp
    bus.log2_nave = 4'd0; bus.mode = 1'b0;
    for (int i = 0; i < 20; i++) begin
      v = {16'(4 * i + 3), 16'(4 * i + 2), 16'(4 * i + 1), 16'(4 * i)} * 64'd257;
      beat(v, 1'b0);
      chk("t3_pass", bus.data_out, v);
    end

    // k=4 with sync+valid on 7th beat
    bus.log2_nave = 4'd4;
    for (int i = 0; i < 6; i++) beat({4{16'(100 + 50 * i)}}, 1'b0);
    beat({16'd9, 16'd500, 16'd3, 16'd60000}, 1'b1);
    for (int i = 0; i < 15; i++) beat({16'(i), 16'(7 * i), 16'(1000 + i), 16'(i * 300)}, 1'b0);

    // sync without valid discards partial integration
    bus.log2_nave = 4'd2;
    beat({4{16'd500}}, 1'b0);
    beat({4{16'd500}}, 1'b0);
    idle(1, 1'b1);
    for (int i = 0; i < 4; i++) beat({4{16'(20 + i)}}, 1'b0);
    chk("t4_sync_idle", bus.data_out, {4{16'd22}});

    // mid-integration config change, then clamp of 15 to 8
    bus.log2_nave = 4'd2;
    beat({4{16'd1}}, 1'b0);
    beat({4{16'd2}}, 1'b0);
    bus.log2_nave = 4'd5;
    beat({4{16'd3}}, 1'b0);
    beat({4{16'd4}}, 1'b0);
    chk("t5_k2_done", bus.data_out, {4{16'd3}});
    for (int i = 0; i < 32; i++) begin
      beat({16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)}, 1'b0);
      if (i == 1) bus.mode = 1'b1;
    end
    bus.log2_nave = 4'd15;
    for (int i = 0; i < 256; i++)
      beat({16'($urandom), 16'($urandom), 16'(i), 16'd1}, 1'b0);
    chk("t5_clamp_lane0", bus.data_out[15:0], 16'd256);

    // gaps within k=2 mean, then reset mid-integration
    bus.log2_nave = 4'd2; bus.mode = 1'b0;
    beat({16'd1, 16'd2, 16'd3, 16'd10}, 1'b0); idle(5, 1'b0);
    beat({16'd1, 16'd2, 16'd3, 16'd11}, 1'b0);
    beat({16'd1, 16'd2, 16'd3, 16'd12}, 1'b0); idle(3, 1'b0);
    beat({16'd1, 16'd2, 16'd4, 16'd13}, 1'b0);
    chk("t6_gap_lane0", bus.data_out[15:0], 16'd12);
    beat({4{16'd77}}, 1'b0);
    beat({4{16'd77}}, 1'b0);
    idle(1, 1'b0);
    rst = 1'b1;
    @(posedge clk_data); #1;
    chk_zero_outputs("t6_rst");
    rst = 1'b0;
    model_reset();
    idle(4, 1'b0);
    for (int i = 0; i < 4; i++) beat({4{16'(5 + i)}}, 1'b0);
    chk("t6_post_count", bus.int_count, 32'd1);
    chk("t6_post_data",  bus.data_out, {4{16'd7}});

    idle(3, 1'b0);
    chk("queue_drained", 64'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ave_filterbank_int.md
# ave_filterbank_int

Parametrised successor to the per-channel averaging filterbank. It accepts one beat of NOF_CHANNEL/2 parallel unsigned power samples per valid cycle and integrates each lane over a runtime-selectable 2^k beats, with 0 ≤ k ≤ MAX_LOG2_NAVE. At the end of each integration it emits one beat holding either the rounded mean or the saturated sum. It sits between the channeliser power stage and the FRB search/packetiser, and supports re-alignment to an external sync.

## Interface
Parameters:
- DATA_WIDTH, 16, unsigned input sample width per lane
- NOF_CHANNEL, 128, total channels; lane count LANES = NOF_CHANNEL/2
- MAX_LOG2_NAVE, 8, maximum k; accumulator width ACC_W = DATA_WIDTH + MAX_LOG2_NAVE
- OUT_WIDTH, 16, output sample width per lane (≥ DATA_WIDTH)

Ports:
- clk_data  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- data_in  in  DATA_WIDTH*LANES  lane m at bits [m*DATA_WIDTH +: DATA_WIDTH]
- data_in_valid  in  1  beat qualifier
- sync  in  1  restart integration; discards any partial integration
- log2_nave  in  4  requested k; values above MAX_LOG2_NAVE clamp to MAX_LOG2_NAVE
- mode  in  1  0 = rounded mean, 1 = saturated sum
- data_out  out  OUT_WIDTH*LANES  lane m at bits [m*OUT_WIDTH +: OUT_WIDTH]
- data_out_valid  out  1  one-cycle pulse per completed integration
- sat_flag  out  1  sticky: set when any lane saturates in sum mode
- int_count  out  32  number of completed integrations; wraps at 2^32

## Operation
- Lanes are independent and identical. A single shared beat counter `cnt` (MAX_LOG2_NAVE bits) and a shared config latch (k_lat, mode_lat) serve all lanes.
- First beat of an integration is a valid beat with cnt == 0, or a valid beat with sync high:
  - k_lat ← clamp(log2_nave), mode_lat ← mode
  - acc[m] ← data_in lane m
- Subsequent valid beats: acc[m] ← acc[m] + lane m.
- Every valid beat: cnt ← (cnt == 2^k_lat − 1) ? 0 : cnt + 1. The beat where cnt == 2^k_lat − 1 is the final beat. The comparison uses the k_lat value that applies to that beat, i.e. the new value on a first beat.
- Final beat: sum S[m] = acc[m] + lane m, computed combinationally and registered into data_out.
  - mode_lat = 0: out[m] = (S[m] + (k_lat ? 2^(k_lat−1) : 0)) >> k_lat, round half up. The result always fits in DATA_WIDTH and is zero-extended to OUT_WIDTH.
  - mode_lat = 1: out[m] = min(S[m], 2^OUT_WIDTH − 1). Any clamped lane sets sat_flag.
- k = 0: every valid beat is both first and final, giving 1-cycle pass-through (mean) or zero-extend (sum).
- sync without data_in_valid: cnt ← 0 and the partial integration is discarded; the next valid beat is a first beat. sync with data_in_valid: that beat is the first beat of a new integration.
- Config changes mid-integration are ignored until the next first beat.
- Invalid cycles (data_in_valid = 0) leave acc and cnt unchanged. Gaps of any length are allowed.
- Accumulator width ACC_W never overflows: 2^MAX_LOG2_NAVE × (2^DATA_WIDTH − 1) < 2^ACC_W.

## Timing
- Reset values: data_out = 0, data_out_valid = 0, sat_flag = 0, int_count = 0, cnt = 0, acc = 0, k_lat = 0, mode_lat = 0.
- rst mid-integration drops the partial result. No data_out_valid is produced for it.
- Latency: data_out_valid is high exactly in the cycle after the final beat's clock edge, with data_out stable in that same cycle.
- data_out holds its value until the next completed integration.
- int_count increments in the same cycle that data_out_valid is asserted.
- No backpressure. Minimum output spacing equals 2^k_lat valid beats, so with k = 0 and continuous input, data_out_valid can be high every cycle.
- sat_flag is cleared only by rst.
- Exactly one register stage is allowed on the output path. Any extra pipelining must keep the 1-cycle latency visible at the ports.

## Test plan
- Reset, k = 2, mode = 0, four valid beats with lane 0 = 10, 11, 12, 13. Required: one data_out_valid pulse one cycle after the 4th beat; lane 0 = 12 (46/4 = 11.5 rounds half up to 12); int_count = 1.
- k = 3, mode = 1, OUT_WIDTH = 16, all lanes at 0xFFFF for 8 beats. Required: every lane = 0xFFFF, sat_flag = 1. Then feed 8 beats of 1. Required: lanes = 8, sat_flag still 1.
- k = 0, continuous data_in_valid with ramping data. Required: data_out_valid high every cycle; data_out equals the input delayed by one cycle.
- k = 4, assert sync with data_in_valid on the 7th beat, then 15 more beats. Required: no output after the first 6 beats; the next output is the mean of the 16 beats starting at the sync beat.
- log2_nave changed from 2 to 5 after the 2nd beat. Required: the current integration completes at 4 beats with k = 2; the next integration needs 32 beats. log2_nave = 15 with MAX = 8 clamps to 256 beats.
- Invalid gaps of 0–5 cycles between the 4 beats of a k = 2 integration, with rst asserted mid-way through a second integration. Required: the first result is unchanged by the gaps; the second produces no output; all outputs are 0 on the cycle after rst.
